morse_char_uart_buffer: RTL
===========================

Name: morse_char_uart_buffer

Overview:
- Downstream consumer of the Morse translator top level (top_2).
- Captures each decoded ASCII character presented on letter/ready into a small FIFO, then serializes the queued characters over a UART TX line so a host terminal can display the translated message.
- Decouples operator keying rate from UART rate; reports fill level and overflow.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
- DEPTH, 16, FIFO entries; power of 2, >= 2
- CNT_W, $clog2(DEPTH)+1, width of the level output

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- letter  input  8  ASCII character from the translator; valid only while ready=1
- ready  input  1  single-cycle strobe; one character per high cycle
- tx  output  1  UART serial out, idle high
- tx_busy  output  1  high while a frame is on the line
- level  output  CNT_W  characters currently queued, excluding the one being transmitted
- full  output  1  level==DEPTH
- overflow  output  1  sticky; set when a character is dropped

Behaviour:
- Reset: tx=1, tx_busy=0, level=0, full=0, overflow=0. FSM goes to IDLE, FIFO pointers go to 0, baud counter goes to 0. Reset during a frame aborts it; tx returns high on the next edge.
- Write: a write occurs on a cycle with ready=1 && letter!=8'h00 && !full. 8'h00 is the translator's "no match" code and is silently ignored: no write, no overflow.
- Overflow: ready=1 with full=1 drops the character and sets overflow. overflow clears only on rst.
- Full is sampled before the same-cycle pop. A write while full is dropped even if a pop happens in that cycle.
- Simultaneous write and pop when not full: level is unchanged, both operations take effect.
- Pointers wrap modulo DEPTH. level is a registered up/down count.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: when level!=0, pop the head into the shift register, go to START, tx_busy=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE. tx_busy falls when entering IDLE.
- Back-to-back frames: if level!=0 on return to IDLE, the next START begins the following cycle. The one IDLE cycle between frames is required.
- Latency: ready at cycle N with an empty FIFO gives a write at edge N; IDLE sees level=1 at N+1 and pops; tx falls at edge N+2.
- Baud counter counts 0..CLKS_PER_BIT-1. A bit boundary occurs when the count reaches CLKS_PER_BIT-1. The counter reloads to 0 on each state or bit change.
- A full frame is 10*CLKS_PER_BIT cycles of non-idle line time, or 11*CLKS_PER_BIT with parity.
- Space characters (8'h20) are queued and sent like any other character.

Optional Feature:
- Macro MORSE_UART_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- When undefined: plain 8N1 and the PARITY state does not exist.

Decomposition:
- Shared package morse_pkg:
  - UART FSM state enum
  - ASCII constants: CHAR_NONE=8'h00, CHAR_SPACE=8'h20
  - UART_IDLE_LVL=1'b1
- Sub-module uart_tx_core: owns the baud counter, shift register, FSM and tx/tx_busy. Handshake is load/data_in/busy.
- The top level holds the FIFO, level, full and overflow, and issues load when IDLE && level!=0.

Test Plan:
- CLKS_PER_BIT=4, DEPTH=4 for all tests.
- Single char: ready pulse with letter=8'h4C ('L') -> tx low 2 cycles later, for 4 cycles; then data 0,0,1,1,0,0,1,0 at 4 cycles each; then stop 1; tx_busy high for 40 cycles, then level=0.
- Two chars: 'L' then 'A' (8'h41) 3 cycles apart -> level peaks at 1; 'A' frame (bits 1,0,0,0,0,0,1,0) starts exactly 1 cycle after the 'L' stop bit ends.
- Overflow: 6 ready pulses on consecutive cycles ('A'..'F') -> first popped to TX, next 4 queued with full=1, 6th dropped; overflow=1; line sends A,B,C,D,E in order.
- Ignore code: ready with letter=8'h00 -> level stays 0, tx stays 1, overflow stays 0.
- Reset mid-frame: rst for 1 cycle during DATA bit 3 -> next edge tx=1, tx_busy=0, level=0, overflow=0; a new 'L' afterward transmits correctly.
- Parity (MORSE_UART_PARITY_EN defined): 'L' (three 1s) -> parity bit 1 after bit 7, frame is 44 cycles.

Source files
------------

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse character UART buffer:
//   - uart_state_e : UART transmitter FSM state encoding
//   - CHAR_NONE    : translator "no match" code, never queued
//   - CHAR_SPACE   : word gap character, queued and sent like any other
//   - UART_IDLE_LVL: line level while idle / during the stop bit
//   - even_parity(): parity bit helper for the optional parity state
// Configuration macro: MORSE_UART_PARITY_EN adds the UART_PARITY state.
// -----------------------------------------------------------------------------
package morse_pkg;

`ifdef MORSE_UART_PARITY_EN
   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_PARITY,
      UART_STOP
   } uart_state_e;
`else
   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_e;
`endif

   localparam logic [7:0] CHAR_NONE      = 8'h00;
   localparam logic [7:0] CHAR_SPACE     = 8'h20;
   localparam logic       UART_IDLE_LVL  = 1'b1;
   localparam int         UART_DATA_BITS = 8;

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage : morse_pkg

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Single-character UART transmitter (8N1, or 8E1 with MORSE_UART_PARITY_EN).
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset; aborts a frame in progress
//   load     in   accept data_in; honoured only while busy=0
//   data_in  in   8-bit character to send, LSB first
//   tx       out  registered serial line, idle high
//   busy     out  high from the cycle after load until the frame's FSM
//                 returns to idle
// Configuration macro: MORSE_UART_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
// -----------------------------------------------------------------------------
module uart_tx_core
   import morse_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy
);

   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        data_q, data_d;
   logic              tx_q, tx_d;
   logic              baud_last;

   assign baud_last = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));

   // State register (all flops of the transmitter).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= UART_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         data_q     <= '0;
         tx_q       <= UART_IDLE_LVL;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         tx_q       <= tx_d;
      end
   end

   // Next-state logic. The baud counter restarts from 0 on every state or
   // bit change so each bit lasts exactly CLKS_PER_BIT cycles.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q + BAUD_W'(1);
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      case (state_q)
         UART_IDLE: begin
            baud_cnt_d = '0;
            if (load) begin
               data_d    = data_in;
               bit_idx_d = '0;
               state_d   = UART_START;
            end
         end
         UART_START: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               state_d    = UART_DATA;
            end
         end
         UART_DATA: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef MORSE_UART_PARITY_EN
                  state_d = UART_PARITY;
`else
                  state_d = UART_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef MORSE_UART_PARITY_EN
         UART_PARITY: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               state_d    = UART_STOP;
            end
         end
`endif
         UART_STOP: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               state_d    = UART_IDLE;
            end
         end
         default: begin
            baud_cnt_d = '0;
            state_d    = UART_IDLE;
         end
      endcase
   end

   // Output logic. The line level is decoded from the current state and
   // registered, so tx trails the state by one cycle and is glitch free.
   always_comb begin
      tx_d = UART_IDLE_LVL;
      case (state_q)
         UART_START:  tx_d = ~UART_IDLE_LVL;
         UART_DATA:   tx_d = data_q[bit_idx_q];
`ifdef MORSE_UART_PARITY_EN
         UART_PARITY: tx_d = even_parity(data_q);
`endif
         default:     tx_d = UART_IDLE_LVL;
      endcase
   end

   assign tx   = tx_q;
   assign busy = (state_q != UART_IDLE);

endmodule : uart_tx_core

// File: rtl/morse_char_uart_buffer.sv
// -----------------------------------------------------------------------------
// morse_char_uart_buffer
// Queues decoded Morse characters in a small FIFO and streams them out over a
// UART TX line, decoupling keying rate from line rate.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   letter    in   ASCII character, valid while ready=1 (8'h00 = no match)
//   ready     in   one-cycle strobe, one character per high cycle
//   tx        out  UART serial out, idle high
//   tx_busy   out  frame in progress
//   level     out  characters queued, not counting the one on the line
//   full      out  level == DEPTH
//   overflow  out  sticky: a character was dropped because the FIFO was full
// Configuration macro: MORSE_UART_PARITY_EN selects 8E1 framing instead of 8N1.
// -----------------------------------------------------------------------------
module morse_char_uart_buffer
   import morse_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH        = 16,
   parameter int CNT_W        = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       letter,
   input  logic             ready,
   output logic             tx,
   output logic             tx_busy,
   output logic [CNT_W-1:0] level,
   output logic             full,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic             overflow_q, overflow_d;

   logic             char_valid;
   logic             full_now;
   logic             wr_en;
   logic             pop;
   logic             core_busy;

   // Full is judged on the registered level, i.e. before any same-cycle
   // pop, so a character arriving while full is dropped even if a slot is
   // being freed in that very cycle.
   always_comb begin
      char_valid = ready && (letter != CHAR_NONE);
      full_now   = (level_q == CNT_W'(DEPTH));
      wr_en      = char_valid && !full_now;
      pop        = !core_busy && (level_q != '0);
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q | (char_valid & full_now);
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, pop})
         2'b10:   level_d = level_q + CNT_W'(1);
         2'b01:   level_d = level_q - CNT_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage has no reset; entries are only ever read after being written.
   // The head is read combinationally so a pop can load the transmitter in
   // the same cycle it is decided.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[wr_ptr_q] <= letter;
      end
   end

   uart_tx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_core (
      .clk     (clk),
      .rst     (rst),
      .load    (pop),
      .data_in (mem_q[rd_ptr_q]),
      .tx      (tx),
      .busy    (core_busy)
   );

   assign tx_busy  = core_busy;
   assign level    = level_q;
   assign full     = full_now;
   assign overflow = overflow_q;

endmodule : morse_char_uart_buffer
